cop_instr_sequencer: RTL and testbench

Program sequencer for the matrix coprocessor. It holds a small instruction program (22-bit words: [21:20] flags, [19:12] data, [11:10] matrix select, [9:7] row, [6:4] col, [3:0] opcode) and issues it word by word. Each issue drives the coprocessor's instruction bus with a one-cycle start pulse, then waits for the coprocessor's done handshake. Supports free-run and single-step modes, so it replaces manual button stepping through instruction lists.

---
 rtl/cop_instr_sequencer.sv | 117 +++++++++++
 tb/tb_cop_instr_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_instr_sequencer.sv
// Program sequencer for the matrix coprocessor. It stores a short instruction list and
// issues one word at a time, each with a start pulse, then waits for the cop_done handshake.
module cop_instr_sequencer #(
  parameter int INSTR_W = 22,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               run,
  input  logic               step_mode,
  input  logic               step,
  input  logic               abort,
  input  logic               cop_done,
  output logic [INSTR_W-1:0] instr,
  output logic               start,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               timeout_err
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      OP_HALT = 4'b0000;

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT, ADVANCE, PAUSE, DONE, ERR
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   mem [DEPTH];
  logic [CNT_W-1:0]     wait_cnt;
  logic [ADDR_W:0]      eff_len;
  logic                 last_instr;

  assign eff_len    = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last_instr = (({1'b0, pc} + 1'b1) == eff_len);

  // NOTE: program memory has no reset; contents must survive rst and it maps onto RAM.
  always_ff @(posedge clk) begin
    if (load_en && !busy) mem[load_addr] <= load_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERR: if (run) state_d = (eff_len == '0) ? DONE : FETCH;
        FETCH:           state_d = ISSUE;
        // start is only raised for a non-halt word, so it doubles as the halt decode here
        ISSUE:           state_d = start ? WAIT : DONE;
        WAIT: begin
          if (cop_done)                            state_d = ADVANCE;
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) state_d = ERR;
        end
        ADVANCE: begin
          if (last_instr)     state_d = DONE;
          else if (step_mode) state_d = PAUSE;
          else                state_d = FETCH;
        end
        PAUSE:           if (step) state_d = FETCH;
        default:         state_d = IDLE;
      endcase
    end
  end

  // The instr register is the memory read register: the word addressed in FETCH lands
  // in instr on the same edge that raises start, giving ISSUE a valid word and pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      instr    <= '0;
      start    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      start <= 1'b0;
      if (abort) begin
        pc <= '0;
      end else begin
        unique case (state_q)
          IDLE, DONE, ERR: if (run && eff_len != '0) pc <= '0;
          FETCH: begin
            if (mem[pc][3:0] != OP_HALT) begin
              instr <= mem[pc];
              start <= 1'b1;
            end
          end
          ISSUE:   wait_cnt <= '0;
          WAIT:    wait_cnt <= wait_cnt + 1'b1;
          ADVANCE: if (!last_instr) pc <= pc + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign busy        = (state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT) ||
                       (state_q == ADVANCE) || (state_q == PAUSE);
  assign halted      = (state_q == DONE);
  assign timeout_err = (state_q == ERR);

endmodule

// File: tb/tb_cop_instr_sequencer.sv
// Directed bench for cop_instr_sequencer: a short program is loaded and run in free-run,
// single-step, timeout, halt-marker, reset, abort and zero-length scenarios.
module tb_cop_instr_sequencer;

  localparam int INSTR_W = 22;
  localparam int DEPTH   = 32;
  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [ADDR_W:0]    prog_len;
  logic               run, step_mode, step, abort, cop_done;
  logic [INSTR_W-1:0] instr;
  logic               start;
  logic [ADDR_W-1:0]  pc;
  logic               busy, halted, timeout_err;

  cop_instr_sequencer #(
    .INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .run(run), .step_mode(step_mode), .step(step), .abort(abort),
    .cop_done(cop_done), .instr(instr), .start(start), .pc(pc), .busy(busy),
    .halted(halted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int nstarts  = 0;
  int consec   = 0;
  int dly      = 0;
  int n0;
  logic prev_start = 1'b0;
  logic auto_done  = 1'b0;
  logic [INSTR_W-1:0] instr_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle; also acts as the coprocessor model (done 3 cycles after start).
  task automatic tick();
    @(posedge clk);
    #1;
    if (start && prev_start) consec++;
    prev_start = start;
    if (auto_done) begin
      cop_done = 1'b0;
      if (start) dly = 3;
      else if (dly > 0) begin
        dly--;
        if (dly == 0) cop_done = 1'b1;
      end
    end
    if (start) begin
      nstarts++;
      instr_log.push_back(instr);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic run_pulse();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic set_auto(input logic en);
    auto_done = en; dly = 0; cop_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; prog_len = '0;
    run = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0; cop_done = 1'b0;
    ticks(2);
    check("rst_instr", instr, 0);
    check("rst_start", start, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_tmo", timeout_err, 0);
    rst = 1'b0;
    tick();

    // Free-run two-instruction program
    load(5'd0, 22'h202012);
    load(5'd1, 22'h000003);
    prog_len = 6'd2;
    set_auto(1'b1);
    n0 = nstarts; instr_log.delete();
    run_pulse();
    check("fr_fetch_busy", busy, 1);
    check("fr_fetch_start", start, 0);
    tick();
    check("fr_latency_start", start, 1);
    check("fr_instr0", instr, 22'h202012);
    ticks(20);
    check("fr_nstarts", nstarts - n0, 2);
    check("fr_log1", instr_log[1], 22'h000003);
    check("fr_instr_hold", instr, 22'h000003);
    check("fr_halted", halted, 1);
    check("fr_pc", pc, 1);
    check("fr_busy", busy, 0);

    // Single-step: pause after the first instruction
    step_mode = 1'b1;
    n0 = nstarts;
    run_pulse();
    ticks(6);
    check("ss_pause_busy", busy, 1);
    ticks(20);
    check("ss_pause_nostart", nstarts - n0, 1);
    check("ss_pause_busy2", busy, 1);
    check("ss_pause_pc", pc, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("ss_step_nostart", start, 0);
    tick();
    check("ss_step_start", start, 1);
    check("ss_step_instr", instr, 22'h000003);
    ticks(10);
    check("ss_halted", halted, 1);
    step_mode = 1'b0;

    // Timeout: the coprocessor never answers
    set_auto(1'b0);
    run_pulse();
    ticks(16);
    check("tmo_before", timeout_err, 0);
    check("tmo_before_busy", busy, 1);
    tick();
    check("tmo_err", timeout_err, 1);
    check("tmo_busy", busy, 0);
    run_pulse();
    check("tmo_clear", timeout_err, 0);
    check("tmo_restart_pc", pc, 0);
    tick();
    check("tmo_restart_start", start, 1);
    check("tmo_restart_instr", instr, 22'h202012);

    // Abort during WAIT; a later cop_done must be ignored
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_pc", pc, 0);
    check("abort_instr_kept", instr, 22'h202012);
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    tick();
    check("abort_done_ignored_busy", busy, 0);
    check("abort_done_ignored_start", start, 0);

    // Halt marker at addr1: addr2 must never be issued
    load(5'd1, 22'h000000);
    load(5'd2, 22'h000005);
    prog_len = 6'd3;
    set_auto(1'b1);
    n0 = nstarts; instr_log.delete();
    run_pulse();
    ticks(20);
    check("halt_nstarts", nstarts - n0, 1);
    check("halt_halted", halted, 1);
    check("halt_pc", pc, 1);
    check("halt_instr", instr, 22'h202012);

    // Reset during WAIT, then memory must survive
    load(5'd1, 22'h000003);
    prog_len = 6'd2;
    set_auto(1'b0);
    run_pulse();
    ticks(2);
    check("rstw_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rstw_instr", instr, 0);
    check("rstw_busy0", busy, 0);
    check("rstw_pc", pc, 0);
    check("rstw_start", start, 0);
    tick();
    rst = 1'b0;
    tick();

    // Re-run; a write to addr1 while busy must be dropped
    set_auto(1'b1);
    n0 = nstarts; instr_log.delete();
    run_pulse();
    load(5'd1, 22'h3FFFFF);
    ticks(20);
    check("rerun_nstarts", nstarts - n0, 2);
    check("rerun_log0", instr_log[0], 22'h202012);
    check("rerun_log1", instr_log[1], 22'h000003);
    instr_log.delete();
    run_pulse();
    ticks(20);
    check("busywr_log1", instr_log[1], 22'h000003);
    check("busywr_halted", halted, 1);

    // prog_len = 0 goes straight to DONE
    prog_len = 6'd0;
    n0 = nstarts;
    run_pulse();
    check("zero_halted", halted, 1);
    check("zero_busy", busy, 0);
    ticks(5);
    check("zero_nostart", nstarts - n0, 0);

    // run and abort together: abort wins
    prog_len = 6'd2;
    run = 1'b1; abort = 1'b1;
    tick();
    run = 1'b0; abort = 1'b0;
    check("runabort_busy", busy, 0);
    check("runabort_halted", halted, 0);

    check("start_never_consecutive", consec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
